// File: rtl/cpu_pkg.sv
// Shared definitions for the word-to-byte memory responder: FSM state
// encoding, default memory size, and the address range test.
package cpu_pkg;

    localparam int MEM_AW_DEFAULT = 14;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_CAP,
        WR_LO,
        WR_HI,
        RESP
    } state_e;

    // True when any address bit above the memory's byte-address width is set.
    function automatic logic addr_oob(input logic [15:0] addr, input int aw);
        return (32'(addr) >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/word_mem_responder_if.sv
// Request/response handshake between the control unit (master) and the
// word memory responder (slave).
interface word_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/word_mem_responder.sv
// Serialises 16-bit little-endian word loads/stores onto a byte-wide memory,
// one byte per cycle, and returns a single held response per request.
module word_mem_responder
    import cpu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    word_mem_responder_if.slave   bus,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [MEM_AW-1:0] addr_hi;

    // High byte address wraps within the memory.
    assign addr_hi = addr_q + MEM_AW'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no
    // branch of the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_wdata     = '0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr[MEM_AW-1:0];
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = addr_oob(bus.req_addr, MEM_AW);
                    if (err_d)              state_d = RESP;
                    else if (bus.req_write) state_d = WR_LO;
                    else                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                mem_addr = addr_q;
                mem_re   = 1'b1;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr     = addr_hi;
                mem_re       = 1'b1;
                rdata_d[7:0] = mem_rdata;
                state_d      = RD_CAP;
            end
            RD_CAP: begin
                rdata_d[15:8] = mem_rdata;
                state_d       = RESP;
            end
            WR_LO: begin
                mem_addr  = addr_q;
                mem_we    = 1'b1;
                mem_wdata = wdata_q[7:0];
                state_d   = WR_HI;
            end
            WR_HI: begin
                mem_addr  = addr_hi;
                mem_we    = 1'b1;
                mem_wdata = wdata_q[15:8];
                state_d   = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset arriving mid-access must not let the pending byte strobe land.
        if (!reset) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

endmodule

// File: tb/tb_word_mem_responder.sv
// Directed bench for word_mem_responder: byte memory model, word stores and
// loads, range errors, backpressure, mid-access reset and back-to-back loads.
module tb_word_mem_responder;
    import cpu_pkg::*;

    localparam int AW = MEM_AW_DEFAULT;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic [7:0]    mem [0:(1<<AW)-1];

    int n_checks   = 0;
    int n_bad      = 0;
    int n_conflict = 0;
    int n_strobe   = 0;

    word_mem_responder_if bus ();

    word_mem_responder #(.MEM_AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Byte memory: synchronous write, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we && mem_re) n_conflict++;
        if (mem_we || mem_re) n_strobe++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a) ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.req_ready) check("accept_timeout", 32'd0, 32'd1);
        tick();
        // Scramble the request fields; the DUT must use its registered copy.
        bus.req_valid = 1'b0;
        bus.req_write = ~wr;
        bus.req_addr  = 16'hFFFF;
        bus.req_wdata = 16'h0F0F;
    endtask

    // Called #1 after the accepting edge; lat counts cycles to rsp_valid.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_rsp(input int hold, output logic [15:0] rdata, output logic err);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rdata", 32'(bus.rsp_rdata), 32'(rdata));
            check("hold_err", 32'(bus.rsp_err), 32'(err));
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          input int hold, output logic [15:0] rdata, output logic err,
                          output int lat);
        issue(wr, addr, wd);
        wait_rsp(lat);
        finish_rsp(hold, rdata, err);
    endtask

    initial begin
        logic [15:0] rd;
        logic        er;
        int          lat;
        int          s0;
        logic        seen;

        for (int i = 0; i < (1 << AW); i++) mem[i] = init_byte(i);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;
        bus.rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b1;
        tick();

        // Store 0xBEEF at 0x0100, then load it back
        access(1'b1, 16'h0100, 16'hBEEF, 0, rd, er, lat);
        check("st_beef_lat", 32'(lat), 32'd3);
        check("st_beef_err", 32'(er), 32'd0);
        check("st_beef_rdata", 32'(rd), 32'd0);
        check("st_beef_b0", 32'(mem[14'h0100]), 32'hEF);
        check("st_beef_b1", 32'(mem[14'h0101]), 32'hBE);
        access(1'b0, 16'h0100, 16'h0000, 0, rd, er, lat);
        check("ld_beef_lat", 32'(lat), 32'd4);
        check("ld_beef_rdata", 32'(rd), 32'hBEEF);
        check("ld_beef_err", 32'(er), 32'd0);

        // Store across the top of memory: high byte wraps to 0x0000
        access(1'b1, 16'h3FFF, 16'h1234, 0, rd, er, lat);
        check("st_wrap_b0", 32'(mem[14'h3FFF]), 32'h34);
        check("st_wrap_b1", 32'(mem[14'h0000]), 32'h12);
        access(1'b0, 16'h3FFF, 16'h0000, 0, rd, er, lat);
        check("ld_wrap_rdata", 32'(rd), 32'h1234);
        check("ld_wrap_err", 32'(er), 32'd0);

        // Unaligned load: 0x0101=0xBE, 0x0102 still holds 0x02^0xA5=0xA7
        access(1'b0, 16'h0101, 16'h0000, 0, rd, er, lat);
        check("ld_unal_rdata", 32'(rd), 32'hA7BE);

        // Out-of-range load and store
        s0 = n_strobe;
        access(1'b0, 16'h4000, 16'h0000, 0, rd, er, lat);
        check("oob_ld_lat", 32'(lat), 32'd1);
        check("oob_ld_err", 32'(er), 32'd1);
        check("oob_ld_rdata", 32'(rd), 32'd0);
        access(1'b1, 16'h8001, 16'hCAFE, 0, rd, er, lat);
        check("oob_st_lat", 32'(lat), 32'd1);
        check("oob_st_err", 32'(er), 32'd1);
        check("oob_strobes", 32'(n_strobe - s0), 32'd0);
        check("oob_st_nowrite", 32'(mem[14'h0001]), 32'(init_byte(1)));

        // Backpressure: rsp_ready low for 5 cycles
        access(1'b0, 16'h0100, 16'h0000, 5, rd, er, lat);
        check("bp_lat", 32'(lat), 32'd4);
        check("bp_rdata", 32'(rd), 32'hBEEF);
        check("bp_err", 32'(er), 32'd0);

        // Reset during WR_HI of store 0xAA55 at 0x0010
        issue(1'b1, 16'h0010, 16'hAA55);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid) seen = 1'b1;
            tick();
        end
        check("rst_st_b0", 32'(mem[14'h0010]), 32'h55);
        check("rst_st_b1", 32'(mem[14'h0011]), 32'(init_byte(16'h0011)));
        check("rst_st_norsp", 32'(seen), 32'd0);
        check("rst_st_ready", 32'(bus.req_ready), 32'd1);

        // Reset during RD_HI of a load discards the response
        issue(1'b0, 16'h0100, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid) seen = 1'b1;
            tick();
        end
        check("rst_ld_norsp", 32'(seen), 32'd0);

        // Back-to-back loads with req_valid held high
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0100;
        check("b2b_ready0", 32'(bus.req_ready), 32'd1);
        tick();
        wait_rsp(lat);
        check("b2b_lat1", 32'(lat), 32'd4);
        check("b2b_rdata1", 32'(bus.rsp_rdata), 32'hBEEF);
        check("b2b_resp_noready", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
        check("b2b_idle_nore", 32'(mem_re), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        check("b2b_acc_ready", 32'(bus.req_ready), 32'd0);
        check("b2b_acc_re", 32'(mem_re), 32'd1);
        check("b2b_acc_addr", 32'(mem_addr), 32'h0100);
        wait_rsp(lat);
        finish_rsp(0, rd, er);
        check("b2b_lat2", 32'(lat), 32'd4);
        check("b2b_rdata2", 32'(rd), 32'hBEEF);

        check("strobe_excl", 32'(n_conflict), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
